fetch_stage: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register that the control unit decodes from. It honours the control unit's `freeze` (e.g. the two-cycle SWP sequence, which re-presents the same instruction) and branch redirects from the execute stage. It drives a request/acknowledge instruction-memory port with variable latency. A one-entry skid buffer ensures no fetched word is lost or duplicated while the pipeline is frozen.

---
 rtl/fetch_stage_if.sv | 17 +
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port.
//   imem_req   : fetch stage requests a word at imem_addr
//   imem_addr  : request address, stable while req=1 and ack=0
//   imem_ack   : memory returns imem_rdata for the current request
//   imem_rdata : fetched instruction word
interface fetch_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 32
);
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the IF/ID register.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   freeze            : hold the IF/ID register
//   branch_taken/addr : redirect from execute (overrides freeze)
//   imem              : instruction-memory port (master side)
//   instr_out/pc_out  : IF/ID word and its PC+4 (zero when bubble)
//   instr_valid       : IF/ID holds a real instruction
//   fetch_stall       : fetch is waiting on memory
module fetch_stage #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    fetch_stage_if.master       imem,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic                instr_valid,
    output logic                fetch_stall
);

    typedef enum logic [1:0] {S_FETCH = 2'd0, S_HELD = 2'd1, S_DROP = 2'd2} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   stale_q, stale_d;
    logic [INSTR_W-1:0]  skid_instr_q, skid_instr_d;
    logic [ADDR_W-1:0]   skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0]  instr_q, instr_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                valid_q, valid_d;
    logic [ADDR_W-1:0]   pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            stale_q      <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            instr_q      <= '0;
            pc_out_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            stale_q      <= stale_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        stale_d      = stale_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;

        // A redirect always flushes IF/ID, frozen or not
        if (branch_taken || !freeze) begin
            instr_d  = '0;
            pc_out_d = '0;
            valid_d  = 1'b0;
        end

        unique case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    pc_d = branch_addr;
                    if (!imem.imem_ack) begin
                        // Outstanding request must still complete at its old address
                        stale_d = pc_q;
                        state_d = S_DROP;
                    end
                end else if (imem.imem_ack) begin
                    pc_d = pc_plus4;
                    if (freeze) begin
                        skid_instr_d = imem.imem_rdata;
                        skid_pc_d    = pc_plus4;
                        state_d      = S_HELD;
                    end else begin
                        instr_d  = imem.imem_rdata;
                        pc_out_d = pc_plus4;
                        valid_d  = 1'b1;
                    end
                end
            end
            S_HELD: begin
                if (branch_taken) begin
                    skid_instr_d = '0;
                    skid_pc_d    = '0;
                    pc_d         = branch_addr;
                    state_d      = S_FETCH;
                end else if (!freeze) begin
                    instr_d  = skid_instr_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_DROP: begin
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
                if (imem.imem_ack) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Memory port and status outputs
    always_comb begin
        imem.imem_req  = 1'b0;
        imem.imem_addr = pc_q;
        fetch_stall    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                imem.imem_req = 1'b1;
                fetch_stall   = !imem.imem_ack;
            end
            S_DROP: begin
                imem.imem_req  = 1'b1;
                imem.imem_addr = stale_q;
                fetch_stall    = 1'b1;
            end
            default: begin
                imem.imem_req = 1'b0;
            end
        endcase
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: zero-wait fetch, wait states, freeze/skid,
// branch during wait, branch+freeze in HELD, PC wrap and reset during DROP.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_stall;

    int errors = 0;
    int checks = 0;

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) imem ();

    fetch_stage #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem         (imem.master),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .fetch_stall  (fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive inputs for the coming edge; settle combinational outputs
    task automatic drive(input logic frz, input logic br, input logic [31:0] ba,
                         input logic ack, input logic [31:0] rd);
        freeze             = frz;
        branch_taken       = br;
        branch_addr        = ba;
        imem.imem_ack      = ack;
        imem.imem_rdata    = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] i, input logic [31:0] p,
                              input logic v);
        check({tag, "_instr"}, instr_out, i);
        check({tag, "_pc"},    pc_out, p);
        check({tag, "_valid"}, 32'(instr_valid), 32'(v));
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 32'h0, 0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        check_ifid("reset", 32'h0, 32'h0, 1'b0);
        check("reset_req",  32'(imem.imem_req), 32'd1);
        check("reset_addr", imem.imem_addr, 32'h0);

        // Zero-wait fetch
        drive(0, 0, 32'h0, 1, 32'h0400_0000);
        check("zw0_addr", imem.imem_addr, 32'h0);
        check("zw0_stall", 32'(fetch_stall), 32'd0);
        tick();
        check_ifid("zw0", 32'h0400_0000, 32'h4, 1'b1);
        drive(0, 0, 32'h0, 1, 32'h0C00_0000);
        check("zw1_addr", imem.imem_addr, 32'h4);
        tick();
        check_ifid("zw1", 32'h0C00_0000, 32'h8, 1'b1);
        drive(0, 0, 32'h0, 1, 32'h1400_0000);
        check("zw2_addr", imem.imem_addr, 32'h8);
        tick();
        check_ifid("zw2", 32'h1400_0000, 32'hC, 1'b1);

        // Two wait states per word
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 2; k++) begin
                drive(0, 0, 32'h0, 0, 32'hBAD0_0000);
                check("ws_addr", imem.imem_addr, 32'hC + 32'(w * 4));
                check("ws_stall", 32'(fetch_stall), 32'd1);
                tick();
                check_ifid("ws_bubble", 32'h0, 32'h0, 1'b0);
            end
            drive(0, 0, 32'h0, 1, 32'h1800_0000 + 32'(w) * 32'h0400_0000);
            check("ws_ack_addr", imem.imem_addr, 32'hC + 32'(w * 4));
            check("ws_ack_stall", 32'(fetch_stall), 32'd0);
            tick();
            check_ifid("ws_word", 32'h1800_0000 + 32'(w) * 32'h0400_0000, 32'h10 + 32'(w * 4), 1'b1);
        end

        // SWP freeze: FC000000 in IF/ID, next word acked while frozen
        drive(0, 0, 32'h0, 1, 32'hFC00_0000);
        check("swp_addr0", imem.imem_addr, 32'h14);
        tick();
        check_ifid("swp_fc", 32'hFC00_0000, 32'h18, 1'b1);
        drive(1, 0, 32'h0, 1, 32'h0400_0000);
        check("swp_addr1", imem.imem_addr, 32'h18);
        tick();
        check_ifid("swp_hold", 32'hFC00_0000, 32'h18, 1'b1);
        drive(0, 0, 32'h0, 0, 32'h0);
        check("swp_held_req", 32'(imem.imem_req), 32'd0);
        check("swp_held_stall", 32'(fetch_stall), 32'd0);
        tick();
        check_ifid("swp_release", 32'h0400_0000, 32'h1C, 1'b1);
        check("swp_next_req", 32'(imem.imem_req), 32'd1);
        check("swp_next_addr", imem.imem_addr, 32'h1C);

        // Branch while the request at 0x1C is unacked
        tick();
        check_ifid("br_wait_bubble", 32'h0, 32'h0, 1'b0);
        drive(0, 1, 32'h40, 0, 32'h0);
        check("br_addr", imem.imem_addr, 32'h1C);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check("drop_req", 32'(imem.imem_req), 32'd1);
        check("drop_addr", imem.imem_addr, 32'h1C);
        check("drop_stall", 32'(fetch_stall), 32'd1);
        check_ifid("drop_bubble", 32'h0, 32'h0, 1'b0);
        tick();
        drive(0, 0, 32'h0, 1, 32'hDEAD_0000);
        check("drop_ack_addr", imem.imem_addr, 32'h1C);
        check("drop_ack_stall", 32'(fetch_stall), 32'd1);
        tick();
        check_ifid("drop_discard", 32'h0, 32'h0, 1'b0);
        drive(0, 0, 32'h0, 0, 32'h0);
        check("br_target_addr", imem.imem_addr, 32'h40);
        check("br_target_req", 32'(imem.imem_req), 32'd1);

        // Branch + freeze together in HELD
        drive(0, 0, 32'h0, 1, 32'h2000_0000);
        tick();
        check_ifid("bf_w0", 32'h2000_0000, 32'h44, 1'b1);
        drive(1, 0, 32'h0, 1, 32'h2400_0000);
        tick();
        check_ifid("bf_hold", 32'h2000_0000, 32'h44, 1'b1);
        drive(1, 1, 32'h100, 0, 32'h0);
        check("bf_held_req", 32'(imem.imem_req), 32'd0);
        tick();
        check_ifid("bf_flush", 32'h0, 32'h0, 1'b0);
        drive(0, 0, 32'h0, 1, 32'h2800_0000);
        check("bf_target_addr", imem.imem_addr, 32'h100);
        tick();
        check_ifid("bf_after", 32'h2800_0000, 32'h104, 1'b1);

        // Branch with same-cycle ack discards; PC wraps past the top
        drive(0, 1, 32'hFFFF_FFFC, 1, 32'hAAAA_0000);
        tick();
        check_ifid("wrap_discard", 32'h0, 32'h0, 1'b0);
        drive(0, 0, 32'h0, 1, 32'h3000_0000);
        check("wrap_addr", imem.imem_addr, 32'hFFFF_FFFC);
        tick();
        check_ifid("wrap_word", 32'h3000_0000, 32'h0, 1'b1);
        check("wrap_next_addr", imem.imem_addr, 32'h0);

        // Reset while in DROP
        drive(0, 0, 32'h0, 1, 32'h3400_0000);
        tick();
        drive(0, 1, 32'h200, 0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check("rd_drop_addr", imem.imem_addr, 32'h4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rd_addr", imem.imem_addr, 32'h0);
        check("rd_req", 32'(imem.imem_req), 32'd1);
        check_ifid("rd_ifid", 32'h0, 32'h0, 1'b0);
        drive(0, 0, 32'h0, 1, 32'h3800_0000);
        check("rd_fetch_stall", 32'(fetch_stall), 32'd0);
        tick();
        check_ifid("rd_first", 32'h3800_0000, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
